// File: rtl/regfile_32x32_pkg.sv
// Shared CPU constants and the register-file write-port decoder.
package regfile_32x32_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    // Slot 0 is hardwired, so it never receives an enable bit.
    function automatic logic [REG_COUNT-1:1] wr_decode(
        input logic                      en,
        input logic [REG_ADDR_WIDTH-1:0] addr
    );
        logic [REG_COUNT-1:1] r;
        r = '0;
        if (en && addr != REG_ZERO) begin
            r[addr] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_32x32_mux32.sv
// mux32: 32-input, WIDTH-bit read-select mux, one per register-file read port.
import regfile_32x32_pkg::*;

module mux32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]          d [REG_COUNT],
    input  logic [REG_ADDR_WIDTH-1:0] sel,
    output logic [WIDTH-1:0]          y
);

    assign y = d[sel];

endmodule

// File: rtl/regfile_32x32_register32.sv
// register32: WIDTH-bit storage flop with load enable and async active-low clear.
module register32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_32x32.sv
// 32x32 register file, r0 hardwired to zero, two async reads, one write.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
import regfile_32x32_pkg::*;

module regfile_32x32 #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [REG_ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegister,
    input  logic [WIDTH-1:0]          WriteData,
    input  logic                      RegWrite,
    output logic [WIDTH-1:0]          ReadData1,
    output logic [WIDTH-1:0]          ReadData2
);

    logic [REG_COUNT-1:1] we;
    logic [WIDTH-1:0]     regs [REG_COUNT];
    logic [WIDTH-1:0]     rd1;
    logic [WIDTH-1:0]     rd2;

    assign we = wr_decode(RegWrite, WriteRegister);
    assign regs[0] = '0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        register32 #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (we[i]),
            .d    (WriteData),
            .q    (regs[i])
        );
    end

    mux32 #(
        .WIDTH(WIDTH)
    ) u_rd1 (
        .d  (regs),
        .sel(ReadRegister1),
        .y  (rd1)
    );

    mux32 #(
        .WIDTH(WIDTH)
    ) u_rd2 (
        .d  (regs),
        .sel(ReadRegister2),
        .y  (rd2)
    );

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1 = RegWrite && WriteRegister == ReadRegister1
                  && WriteRegister != REG_ZERO;
    assign fwd2 = RegWrite && WriteRegister == ReadRegister2
                  && WriteRegister != REG_ZERO;
    assign ReadData1 = fwd1 ? WriteData : rd1;
    assign ReadData2 = fwd2 ? WriteData : rd2;
`else
    assign ReadData1 = rd1;
    assign ReadData2 = rd2;
`endif

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed self-checking bench for regfile_32x32.
module tb_regfile_32x32;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks = 0;
    int failures = 0;

    regfile_32x32 #(
        .WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = a;
        WriteData = d;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        RegWrite = 1'b0;
        WriteRegister = '0;
        WriteData = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;

        // Reset state, with a write attempted while held in reset
        RegWrite = 1'b1;
        WriteRegister = 5'd4;
        WriteData = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        rd(5'd4, 5'd31);
        chk("rst_r4", ReadData1, 32'h0);
        chk("rst_r31", ReadData2, 32'h0);
        RegWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Write to r0 is dropped
        wr(5'd0, 32'h1234_5678);
        rd(5'd0, 5'd0);
        chk("r0_p1", ReadData1, 32'h0);
        chk("r0_p2", ReadData2, 32'h0);

        // Two writes, everything else untouched
        wr(5'd7, 32'hA5A5_A5A5);
        wr(5'd8, 32'h5A5A_5A5A);
        rd(5'd7, 5'd8);
        chk("r7", ReadData1, 32'hA5A5_A5A5);
        chk("r8", ReadData2, 32'h5A5A_5A5A);
        rd(5'd8, 5'd8);
        chk("same_p1", ReadData1, 32'h5A5A_5A5A);
        chk("same_p2", ReadData2, 32'h5A5A_5A5A);
        for (int i = 0; i < 32; i++) begin
            if (i != 7 && i != 8) begin
                rd(5'(i), 5'(31 - i));
                chk($sformatf("zero_p1_%0d", i), ReadData1, 32'h0);
            end
        end

        // RegWrite low: no update
        @(negedge clk);
        RegWrite = 1'b0;
        WriteRegister = 5'd3;
        WriteData = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rd(5'd3, 5'd7);
        chk("nowe_r3", ReadData1, 32'h0);
        chk("nowe_r7", ReadData2, 32'hA5A5_A5A5);

        // Same-cycle read/write of r9
        wr(5'd9, 32'h1111_1111);
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd9;
        WriteData = 32'h2222_2222;
        rd(5'd9, 5'd0);
`ifdef REGFILE_BYPASS_EN
        chk("rw_pre", ReadData1, 32'h2222_2222);
`else
        chk("rw_pre", ReadData1, 32'h1111_1111);
`endif
        chk("rw_pre_r0", ReadData2, 32'h0);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        chk("rw_post", ReadData1, 32'h2222_2222);

        // Same-cycle write to r0 never forwards
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd0;
        WriteData = 32'hFFFF_0000;
        rd(5'd0, 5'd0);
        chk("r0_fwd", ReadData1, 32'h0);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;

        // Fill and sweep
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h100 + 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk($sformatf("sweep_p1_%0d", i), ReadData1,
                (i == 0) ? 32'h0 : 32'h100 + 32'(i));
            chk($sformatf("sweep_p2_%0d", 31 - i), ReadData2,
                (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i));
        end

        // Async reset mid-run clears without a clock edge
        wr(5'd5, 32'hDEAD_BEEF);
        rd(5'd5, 5'd30);
        chk("r5_set", ReadData1, 32'hDEAD_BEEF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_r5", ReadData1, 32'h0);
        chk("async_r30", ReadData2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(5'd5, 32'h0BAD_CAFE);
        rd(5'd5, 5'd30);
        chk("post_rst_r5", ReadData1, 32'h0BAD_CAFE);
        chk("post_rst_r30", ReadData2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_32x32.md
REGFILE_32X32 -- requirements
Module: regfile_32x32

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of each register and of every data port.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all register updates.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low; clears every register.
REQ-004 SHALL have port: ReadRegister1  input  5  address of read port 1.
REQ-005 SHALL have port: ReadRegister2  input  5  address of read port 2.
REQ-006 SHALL have port: WriteRegister  input  5  address of the write port.
REQ-007 SHALL have port: WriteData  input  WIDTH  data for the write port.
REQ-008 SHALL have port: RegWrite  input  1  write enable, sampled on rising clk.
REQ-009 SHALL have port: ReadData1  output  WIDTH  contents of register ReadRegister1.
REQ-010 SHALL have port: ReadData2  output  WIDTH  contents of register ReadRegister2.
REQ-011 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-012 SHALL hold 32 registers of WIDTH bits, indexed 0..31.
REQ-013 SHALL hardwire register 0 to zero; writes to address 0 have no effect; reads of address 0 return 0.
REQ-014 SHALL update register WriteRegister with WriteData on the rising clk edge when RegWrite=1 and rst_n=1; exactly one register changes per write.
REQ-015 SHALL leave all registers unchanged on a rising edge with RegWrite=0.
REQ-016 SHALL produce ReadData1/ReadData2 combinationally from the addressed register (zero-cycle read latency, no clock needed).
REQ-017 SHALL allow both read ports to address the same register simultaneously, returning identical values.
REQ-018 SHALL, without bypass (REQ-023), return the pre-edge (old) value when a read and write target the same register in the same cycle; the new value is visible after the edge.
REQ-019 SHALL decode WriteRegister with a one-hot 5-to-32 write-enable decoder gated by RegWrite; no address wraps or aliases.
REQ-020 SHALL produce no X on ReadData1/ReadData2 after reset for any address.

Reset
REQ-021 SHALL, while rst_n=0, force all 32 registers to 0 immediately (no clock required), so both read ports output 0.
REQ-022 SHALL ignore RegWrite during reset, including a write coinciding with the edge on which rst_n deasserts; the first write takes effect on the first rising edge with rst_n=1 sampled high.

Configuration
REQ-023 SHALL, when macro REGFILE_BYPASS_EN is defined, forward WriteData to ReadDataN whenever RegWrite=1, WriteRegister=ReadRegisterN and WriteRegister!=0 (same-cycle write-to-read forwarding); when undefined, REQ-018 applies and no forwarding logic exists.

Structure
REQ-024 SHALL take constants REG_COUNT=32, REG_ADDR_WIDTH=5, REG_ZERO=5'd0 from the shared CPU package.
REQ-025 SHALL build each storage element from one sub-module, register32 (WIDTH-bit flop, enable, async active-low clear), instantiated for registers 1..31.
REQ-026 SHALL drive read selection through the existing 32-input, 32-bit-wide mux block, one instance per read port.

Verification
REQ-027 SHALL cover: assert rst_n=0 mid-simulation after writing reg 5=0xDEADBEEF -> ReadData1 (addr 5) = 0 before the next clk edge.
REQ-028 SHALL cover: write 0x12345678 to reg 0 -> ReadData1/ReadData2 (addr 0) = 0.
REQ-029 SHALL cover: write reg 7=0xA5A5A5A5, reg 8=0x5A5A5A5A; read 7 and 8 -> 0xA5A5A5A5, 0x5A5A5A5A; all other regs still 0.
REQ-030 SHALL cover: RegWrite=0, WriteRegister=3, WriteData=0xFFFFFFFF, clock -> reg 3 remains 0.
REQ-031 SHALL cover: reg 9=0x11111111, then same-cycle write 0x22222222 to reg 9 with ReadRegister1=9 -> before edge 0x11111111 (no bypass) or 0x22222222 (REGFILE_BYPASS_EN); after edge 0x22222222 both builds.
REQ-032 SHALL cover: write each of regs 1..31 with value 0x100+index, then sweep both read ports over all 32 addresses -> addr 0 reads 0, addr n reads 0x100+n.
